// File: rtl/aep_wr_sched.sv
// aep_wr_sched: write-request scheduler in front of a small bounded register
// array. Requests are buffered in a FIFO, drained one per cycle, bounds-checked
// against the array depth, and out-of-range writes are dropped and counted.
// With HALT_ON_ERR set, an out-of-range write parks the scheduler in HALT
// until clr_err is pulsed.
module aep_wr_sched #(
  parameter int DW          = 2,
  parameter int AW          = 3,
  parameter int MEM_DEPTH   = 2,
  parameter int MAW         = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int HALT_ON_ERR = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  // Request handshake: a request transfers on the rising edge where
  // req_valid && req_ready. req_ready depends only on FIFO fullness (and is
  // forced low during reset); a pop in the same cycle does not free a slot
  // for that cycle's request.
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [AW-1:0]                 req_addr,
  input  logic [DW-1:0]                 req_data,
  input  logic                          mem_stall,
  output logic                          mem_we,
  output logic [MAW-1:0]                mem_waddr,
  output logic [DW-1:0]                 mem_wdata,
  output logic                          oob_err,
  output logic [7:0]                    err_cnt,
  output logic                          halted,
  input  logic                          clr_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          dbg_state
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = AW + DW;

  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [AW-1:0] ADDR_LIM = AW'(MEM_DEPTH);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t state_q, state_d;

  logic [EW-1:0]  fifo_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]  level_q, level_d;

  logic           mem_we_q, mem_we_d;
  logic [MAW-1:0] mem_waddr_q, mem_waddr_d;
  logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
  logic           oob_q, oob_d;
  logic [7:0]     err_q, err_d, err_base;

  logic           full, empty, push, pop, oob_pop;
  logic [EW-1:0]  head;
  logic [AW-1:0]  head_addr;
  logic [DW-1:0]  head_data;
  logic           head_in_range;

  assign full          = (level_q == FULL_LVL);
  assign empty         = (level_q == '0);
  assign req_ready     = !rst && !full;
  assign push          = req_valid && req_ready;
  assign pop           = !empty && !mem_stall && (state_q == RUN);
  assign head          = fifo_q[rd_ptr_q];
  assign head_addr     = head[EW-1:DW];
  assign head_data     = head[DW-1:0];
  assign head_in_range = (head_addr < ADDR_LIM);
  assign oob_pop       = pop && !head_in_range;

  assign mem_we     = mem_we_q;
  assign mem_waddr  = mem_waddr_q;
  assign mem_wdata  = mem_wdata_q;
  assign oob_err    = oob_q;
  assign err_cnt    = err_q;
  assign halted     = (state_q == HALT);
  assign fifo_level = level_q;
  assign dbg_state  = state_q;

  // Request storage: written only on an accepted request, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {req_addr, req_data};
    end
  end

  // Occupancy bookkeeping: push and pop together leave the level unchanged.
  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (pop && !push) begin
      level_d = level_q - LVL_ONE;
    end
  end

  // Next state: an out-of-range pop beats a simultaneous clr_err.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (oob_pop && (HALT_ON_ERR != 0)) begin
          state_d = HALT;
        end
      end
      HALT: begin
        if (clr_err) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Registered array write port and error reporting for the popped entry.
  always_comb begin
    mem_we_d    = 1'b0;
    oob_d       = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    err_base    = clr_err ? 8'd0 : err_q;
    err_d       = err_base;
    if (pop) begin
      if (head_in_range) begin
        mem_we_d    = 1'b1;
        mem_waddr_d = head_addr[MAW-1:0];
        mem_wdata_d = head_data;
      end else begin
        oob_d = 1'b1;
        if (err_base != 8'hFF) begin
          err_d = err_base + 8'd1;
        end
      end
    end
  end

  // State, pointers and output registers; reset discards buffered requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      oob_q       <= 1'b0;
      err_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      oob_q       <= oob_d;
      err_q       <= err_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

endmodule
